// File: rtl/stage_memory.sv
// MEM pipeline stage: word-organised data memory with byte/half/word access,
// misalignment detection and the registered MEM/WB write-back interface.
module stage_memory #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [31:0] i_ALU_res,
  input  logic [31:0] i_rt_reg,
  input  logic [31:0] i_pc_to_reg,
  input  logic [4:0]  i_addr_reg_dst,
  input  logic        is_RegWrite,
  input  logic        is_MemtoReg,
  input  logic        is_MemWrite,
  input  logic        is_MemRead,
  input  logic        is_link,
  input  logic [2:0]  is_load_store_type,
  input  logic [5:0]  i_debug_addr,
  output logic [31:0] o_MEM_WB_reg,
  output logic [4:0]  o_MEM_WB_Rd,
  output logic        os_MEM_WB_RegWrite,
  output logic        os_misaligned,
  output logic [31:0] o_debug_data
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          is_half, is_word, misaligned, store_en;
  logic [3:0]    byte_en;
  logic [31:0]   rd_word, wr_lanes, wr_word, load_data, wb_data;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          unused_addr_bits;

  assign idx              = i_ALU_res[AW+1:2];
  assign lane             = i_ALU_res[1:0];
  assign unused_addr_bits = ^i_ALU_res[31:AW+2];
  assign rd_word          = mem[idx];
  assign o_debug_data     = mem[i_debug_addr[AW-1:0]];

  always_comb begin
    is_half    = (is_load_store_type[1:0] == 2'b01);
    is_word    = (is_load_store_type[1:0] == 2'b11);
    misaligned = (is_MemWrite | is_MemRead) &
                 ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
    store_en   = rst & i_enable & is_MemWrite & ~misaligned;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = {4{i_rt_reg[7:0]}};
    if (is_word) begin
      byte_en  = 4'b1111;
      wr_lanes = i_rt_reg;
    end else if (is_half) begin
      byte_en  = lane[1] ? 4'b1100 : 4'b0011;
      wr_lanes = {2{i_rt_reg[15:0]}};
    end else begin
      byte_en  = 4'b0001 << lane;
    end
    for (int b = 0; b < 4; b++)
      wr_word[8*b +: 8] = byte_en[b] ? wr_lanes[8*b +: 8] : rd_word[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (store_en)
      mem[idx] <= wr_word;
  end

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = 32'd0;
    if (is_MemRead && !misaligned) begin
      case (is_load_store_type)
        3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
        3'b011:  load_data = rd_word;
        3'b100:  load_data = {24'd0, byte_sel};
        3'b101:  load_data = {16'd0, half_sel};
        default: load_data = 32'd0;
      endcase
    end

    if (is_link)
      wb_data = i_pc_to_reg;
    else if (is_MemtoReg)
      wb_data = load_data;
    else
      wb_data = i_ALU_res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_MEM_WB_reg       <= 32'd0;
      o_MEM_WB_Rd        <= 5'd0;
      os_MEM_WB_RegWrite <= 1'b0;
      os_misaligned      <= 1'b0;
    end else if (i_enable) begin
      o_MEM_WB_reg       <= wb_data;
      o_MEM_WB_Rd        <= i_addr_reg_dst;
      // a misaligned load has no valid data, so it must not reach the register file
      os_MEM_WB_RegWrite <= is_RegWrite & ~(misaligned & is_MemRead);
      os_misaligned      <= misaligned;
    end
  end

endmodule

// File: doc/stage_memory.md
STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 64, giving the data memory depth in 32-bit words, word index = i_ALU_res[7:2].
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_enable, input, 1: pipeline advance; when 0 all state holds.
REQ-005 The block SHALL have port i_ALU_res, input, 32: byte address for loads/stores, or the result to write back.
REQ-006 The block SHALL have port i_rt_reg, input, 32: store data, already forwarded.
REQ-007 The block SHALL have port i_pc_to_reg, input, 32: link value for jal/jalr.
REQ-008 The block SHALL have port i_addr_reg_dst, input, 5: destination register.
REQ-009 The block SHALL have the following 1-bit input ports: is_RegWrite, is_MemtoReg, is_MemWrite, is_MemRead, is_link (select i_pc_to_reg for write-back).
REQ-010 The block SHALL have port is_load_store_type, input, 3, with encoding 000 = byte signed, 001 = half signed, 011 = word, 100 = byte unsigned, 101 = half unsigned.
REQ-011 The block SHALL have port i_debug_addr, input, 6: word index for the debug read port.
REQ-012 The block SHALL have port o_MEM_WB_reg, output, 32: registered write-back data, also the MEM/WB forwarding source.
REQ-013 The block SHALL have port o_MEM_WB_Rd, output, 5: registered destination register.
REQ-014 The block SHALL have port os_MEM_WB_RegWrite, output, 1: registered write enable.
REQ-015 The block SHALL have port os_misaligned, output, 1: registered misaligned-access flag.
REQ-016 The block SHALL have port o_debug_data, output, 32: combinational read of word i_debug_addr.

Function
REQ-017 Store: on a rising edge with i_enable=1, is_MemWrite=1 and an aligned address, the block SHALL write the selected lanes.
- Byte: lane i_ALU_res[1:0] gets i_rt_reg[7:0].
- Half: lanes {a1,0} and {a1,1} get i_rt_reg[15:0], little-endian.
- Word: all lanes get i_rt_reg.
- Other lanes unchanged.
REQ-018 Load: when is_MemRead=1, the block SHALL read the word combinationally, then select and extend the lane per type (signed types sign-extend, unsigned zero-extend, word passes through).
REQ-019 Write-back mux, in priority order, SHALL be: is_link -> i_pc_to_reg; is_MemtoReg -> load data; else i_ALU_res.
REQ-020 On a rising edge with i_enable=1, the block SHALL latch the mux result, i_addr_reg_dst and is_RegWrite into o_MEM_WB_reg, o_MEM_WB_Rd and os_MEM_WB_RegWrite, giving 1-cycle latency from input to output.
REQ-021 Misaligned access is half with a[0]=1, or word with a[1:0]!=0. For a misaligned access the block SHALL:
- suppress the store;
- return load data 0;
- register os_misaligned=1 for that cycle;
- force os_MEM_WB_RegWrite=0 for a misaligned load.
REQ-022 os_misaligned SHALL return to 0 on the next enabled edge whose access is aligned or is not a memory access.
REQ-023 With i_enable=0 the block SHALL perform no memory write and SHALL hold all output registers.
REQ-024 If is_MemWrite and is_MemRead are both 1, the block SHALL give the store priority, and the load data SHALL reflect pre-write contents.
REQ-025 Address bits above [7:2] SHALL be ignored, so index wraps modulo MEM_WORDS.
REQ-026 o_debug_data SHALL reflect a store at the same edge on the following cycle.

Reset
REQ-027 While rst=0, the block SHALL force o_MEM_WB_reg=0, o_MEM_WB_Rd=0, os_MEM_WB_RegWrite=0 and os_misaligned=0 immediately, regardless of clk.
REQ-028 While rst=0, the block SHALL perform no memory write, including a store coincident with an edge during reset.
REQ-029 Memory contents SHALL NOT be reset.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Store word 0xDEADBEEF at 0x10, then load word signed at 0x10 -> o_MEM_WB_reg = 0xDEADBEEF one cycle after the load, o_debug_data at index 4 = 0xDEADBEEF.
- Store byte 0x80 at 0x13, then load byte signed at 0x13 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word at 0x10 -> 0x80ADBEEF.
- Store half 0x1234 at 0x21 -> memory unchanged, os_misaligned=1 for one cycle; load half at 0x21 -> os_MEM_WB_RegWrite=0.
- i_enable=0 with a store of 0x55 at 0x08 -> word 2 unchanged, outputs hold previous values; re-enable -> normal operation.
- is_link=1, i_pc_to_reg=0x40, i_addr_reg_dst=31, is_RegWrite=1 -> o_MEM_WB_reg=0x40, o_MEM_WB_Rd=31.
- Assert rst low mid-sequence with a store pending -> outputs 0 asynchronously, target word unchanged.
